// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: FSM state encodings and request bundle.
// STATE_M_BUSY is only reachable when MEM_WAIT_EN is defined.
package data_mem_responder_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int MEM_STATE_LEN = 2;

    typedef enum logic [MEM_STATE_LEN-1:0] {
        STATE_M_IDLE = 2'd0,
        STATE_M_BUSY = 2'd1,
        STATE_M_RESP = 2'd2,
        STATE_M_HOLD = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                  wr;
        logic                  err;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    function automatic logic req_illegal(
        input logic       rd,
        input logic       wr,
        input logic [1:0] lsb
    );
        return (lsb != 2'b00) | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with registered read data and no reset.
// Read data only changes on an enabled read, so it holds between accesses.
module mem_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-state responder: level-held read/write requests, one-cycle mem_ready/mem_err.
// MEM_WAIT_EN enables the LATENCY wait (BUSY + counter); otherwise every request takes one cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ready,
    output logic                  mem_err
);

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int LAT = (WAIT_EN && LATENCY > 1) ? LATENCY : 1;

`ifdef MEM_WAIT_EN
    localparam int CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT > 1) ? LAT - 2 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`endif

    mem_state_e state_q;
    mem_state_e state_d;

    mem_req_t req_q;
    mem_req_t req_live;
    mem_req_t acc_req;

    logic req_any;
    logic cap_en;
    logic acc_en;
    logic ram_en;
    logic rd_valid_q;

    logic [DATA_WIDTH-1:0] ram_q;

    assign req_any = mem_read_flag | mem_write_flag;

    assign req_live = '{
        wr:    mem_write_flag,
        err:   req_illegal(mem_read_flag, mem_write_flag, addr[1:0]),
        addr:  addr,
        wdata: wdata
    };

    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        acc_en  = 1'b0;
        acc_req = req_q;
`ifdef MEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            STATE_M_IDLE: begin
                if (req_any) begin
                    cap_en = 1'b1;
                    if (LAT == 1) begin
                        // single-cycle access uses the live request directly
                        state_d = STATE_M_RESP;
                        acc_en  = ~req_live.err;
                        acc_req = req_live;
                    end else begin
`ifdef MEM_WAIT_EN
                        state_d = STATE_M_BUSY;
                        cnt_d   = CNT_LOAD;
`endif
                    end
                end
            end
`ifdef MEM_WAIT_EN
            STATE_M_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = STATE_M_RESP;
                    acc_en  = ~req_q.err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STATE_M_RESP: begin
                state_d = req_any ? STATE_M_HOLD : STATE_M_IDLE;
            end
            STATE_M_HOLD: begin
                if (!req_any) begin
                    state_d = STATE_M_IDLE;
                end
            end
            default: begin
                state_d = STATE_M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STATE_M_IDLE;
            req_q      <= '0;
            rd_valid_q <= 1'b0;
`ifdef MEM_WAIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                req_q <= req_live;
            end
            if (acc_en && !acc_req.wr) begin
                rd_valid_q <= 1'b1;
            end
`ifdef MEM_WAIT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    // an access landing on the same edge as reset must not reach the RAM
    assign ram_en = acc_en & ~rst;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_req.wr),
        .idx   (acc_req.addr[DEPTH_LOG2+1:2]),
        .wdata (acc_req.wdata),
        .rdata (ram_q)
    );

    // the RAM has no reset, so rdata reads as zero until the first good read
    assign rdata     = rd_valid_q ? ram_q : '0;
    assign mem_ready = (state_q == STATE_M_RESP);
    assign mem_err   = mem_ready & req_q.err;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_req.addr[DATA_WIDTH-1:DEPTH_LOG2+2],
                                acc_req.addr[1:0]};

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array model.
// Expected latency follows MEM_WAIT_EN the same way the design build does.
module tb_data_mem_responder;

    localparam int DL2 = 10;
    localparam int LATENCY = 3;
`ifdef MEM_WAIT_EN
    localparam int EXP_LAT = LATENCY;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] model [1024];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_LOG2 (DL2),
        .LATENCY    (LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .mem_ready      (mem_ready),
        .mem_err        (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        bit err;
        int idx;
        err = (a[1:0] != 2'b00) || (rd && wr);
        idx = int'((a >> 2) % 1024);
        if (!err && wr) model[idx] = d;
        if (!err && rd) exp_rdata = model[idx];
        @(negedge clk);
        mem_read_flag  = rd;
        mem_write_flag = wr;
        addr  = a;
        wdata = d;
        for (int k = 1; k <= EXP_LAT; k++) begin
            @(negedge clk);
            if (k < EXP_LAT) begin
                chk("ready_early", {31'd0, mem_ready}, 32'd0);
                addr  = $urandom;
                wdata = $urandom;
            end else begin
                chk("ready", {31'd0, mem_ready}, 32'd1);
                chk("err", {31'd0, mem_err}, {31'd0, err});
                chk("rdata", rdata, exp_rdata);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("ready_held", {31'd0, mem_ready}, 32'd0);
        end
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        @(negedge clk);
        chk("ready_after", {31'd0, mem_ready}, 32'd0);
        chk("rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        rst = 1'b1;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        addr  = '0;
        wdata = '0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 0);
        end

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
        chk("deadbeef", exp_rdata, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'h13, 32'h0, 0);
        do_req(1'b1, 1'b1, 32'h20, 32'h1, 0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 0);

        do_req(1'b1, 1'b0, 32'h24, 32'h0, 10);
        do_req(1'b1, 1'b0, 32'h28, 32'h0, 0);

        @(negedge clk);
        mem_write_flag = 1'b1;
        addr  = 32'h8;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        chk("pre_rst_ready", {31'd0, mem_ready}, {31'd0, EXP_LAT == 1});
        rst = 1'b1;
        #1;
        if (EXP_LAT == 1) model[2] = 32'h55;
        exp_rdata = '0;
        chk("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("mid_rst_err", {31'd0, mem_err}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        mem_write_flag = 1'b0;
        @(negedge clk);
        chk("rst_hold_ready", {31'd0, mem_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 0);

        do_req(1'b0, 1'b1, 32'h1000, 32'hA5A5_1234, 0);
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, 0);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 0);
        chk("wrap", exp_rdata, 32'hA5A5_1234);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int sel;
            bit r;
            bit w;
            a = (32'($urandom_range(0, 7)) << 12)
              | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            r = (sel < 5) || (sel == 9);
            w = (sel >= 5);
            do_req(r, w, a, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
